// File: rtl/pwm_timebase_ctrl_pkg.sv
// Shared definitions for the PWM timebase controller: FSM encoding and default widths.
package pwm_timebase_ctrl_pkg;

  localparam int unsigned CW_DEF = 16;
  localparam int unsigned PW_DEF = 8;
  localparam int unsigned FW     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_timebase_ctrl_prescaler.sv
// Clock prescaler: emits a tick every div+1 cycles, held at zero while clr is high.
module pwm_prescaler
  import pwm_timebase_ctrl_pkg::*;
#(
  parameter int unsigned PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [PW-1:0] div,
  output logic          tick
);

  logic [PW-1:0] r_cnt;

  // Tick on the cycle where the count has reached the divide value.
  assign tick = (r_cnt == div);

  // Count up, wrap to zero on each tick.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/pwm_timebase_ctrl.sv
// PWM timebase controller: run/drain FSM, period counter and shadowed configuration.
module pwm_timebase_ctrl
  import pwm_timebase_ctrl_pkg::*;
#(
  parameter int unsigned CW = CW_DEF,
  parameter int unsigned PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          oneshot,
  input  logic          cfg_wr,
  input  logic [CW-1:0] cfg_period,
  input  logic [CW-1:0] cfg_compare1,
  input  logic [CW-1:0] cfg_compare2,
  input  logic [FW-1:0] cfg_functions,
  input  logic [PW-1:0] cfg_prescale,
  output logic [CW-1:0] count_val,
  output logic [CW-1:0] period,
  output logic [CW-1:0] compare1,
  output logic [CW-1:0] compare2,
  output logic [FW-1:0] functions,
  output logic          pwm_en,
  output logic          busy,
  output logic          period_done,
  output logic          upd_done
);

  pwm_state_e    r_state;
  pwm_state_e    w_next_state;
  logic          r_oneshot;
  logic          w_oneshot_next;
  logic          r_pwm_en;
  logic          r_busy;

  logic [CW-1:0] r_count;
  logic          w_tick;
  logic          w_clr;
  logic          w_wrap;

  // Active (shadowed) configuration.
  logic [CW-1:0] r_period;
  logic [CW-1:0] r_compare1;
  logic [CW-1:0] r_compare2;
  logic [FW-1:0] r_functions;
  logic [PW-1:0] r_prescale;

  // Staging configuration, applied at the next wrap.
  logic [CW-1:0] r_stg_period;
  logic [CW-1:0] r_stg_compare1;
  logic [CW-1:0] r_stg_compare2;
  logic [FW-1:0] r_stg_functions;
  logic [PW-1:0] r_stg_prescale;
  logic          r_pending;

  logic          r_period_done;
  logic          r_upd_done;

  // Prescaler is held cleared while idle so every run starts phase-aligned.
  assign w_clr  = (r_state == ST_IDLE);
  assign w_wrap = w_tick && !w_clr && (r_count == r_period);

  pwm_prescaler #(.PW(PW)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .div  (r_prescale),
    .tick (w_tick)
  );

  // FSM state register with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_oneshot <= 1'b0;
      r_pwm_en  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_oneshot <= w_oneshot_next;
      r_pwm_en  <= (w_next_state != ST_IDLE);
      r_busy    <= (w_next_state != ST_IDLE);
    end
  end

  // Next-state logic; start wins over stop in IDLE, stop is only honoured in RUN.
  always_comb begin
    w_next_state   = r_state;
    w_oneshot_next = r_oneshot;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state   = ST_RUN;
          w_oneshot_next = oneshot;
        end
      end
      ST_RUN: begin
        if (w_wrap && r_oneshot) begin
          w_next_state = ST_IDLE;
        end else if (stop) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_wrap) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Period counter: zero in IDLE and on the first RUN cycle, advances on ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if ((r_state == ST_IDLE) || (w_next_state == ST_IDLE) || w_wrap) begin
      r_count <= '0;
    end else if (w_tick) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Configuration staging/shadowing and the completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_period        <= '0;
      r_compare1      <= '0;
      r_compare2      <= '0;
      r_functions     <= '0;
      r_prescale      <= '0;
      r_stg_period    <= '0;
      r_stg_compare1  <= '0;
      r_stg_compare2  <= '0;
      r_stg_functions <= '0;
      r_stg_prescale  <= '0;
      r_pending       <= 1'b0;
      r_period_done   <= 1'b0;
      r_upd_done      <= 1'b0;
    end else begin
      r_period_done <= w_wrap;
      r_upd_done    <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (cfg_wr) begin
          r_stg_period    <= cfg_period;
          r_stg_compare1  <= cfg_compare1;
          r_stg_compare2  <= cfg_compare2;
          r_stg_functions <= cfg_functions;
          r_stg_prescale  <= cfg_prescale;
          r_period        <= cfg_period;
          r_compare1      <= cfg_compare1;
          r_compare2      <= cfg_compare2;
          r_functions     <= cfg_functions;
          r_prescale      <= cfg_prescale;
          r_pending       <= 1'b0;
          r_upd_done      <= 1'b1;
        end
      end else begin
        // Apply what was staged before this cycle; a write on the wrap itself waits a period.
        if (w_wrap && r_pending) begin
          r_period    <= r_stg_period;
          r_compare1  <= r_stg_compare1;
          r_compare2  <= r_stg_compare2;
          r_functions <= r_stg_functions;
          r_prescale  <= r_stg_prescale;
          r_upd_done  <= 1'b1;
        end
        if (cfg_wr) begin
          r_stg_period    <= cfg_period;
          r_stg_compare1  <= cfg_compare1;
          r_stg_compare2  <= cfg_compare2;
          r_stg_functions <= cfg_functions;
          r_stg_prescale  <= cfg_prescale;
        end
        r_pending <= cfg_wr || (r_pending && !w_wrap);
      end
    end
  end

  assign count_val   = r_count;
  assign period      = r_period;
  assign compare1    = r_compare1;
  assign compare2    = r_compare2;
  assign functions   = r_functions;
  assign pwm_en      = r_pwm_en;
  assign busy        = r_busy;
  assign period_done = r_period_done;
  assign upd_done    = r_upd_done;

endmodule
